// File: rtl/alu_sequencer_if.sv
// Command and ALU-side signal bundle for alu_sequencer.
// slave is the sequencer; master is the requester plus the ALU.
interface alu_sequencer_if;
    logic        iValid;
    logic        oReady;
    logic [1:0]  iCmd;
    logic [31:0] iA;
    logic [31:0] iB;
    logic [3:0]  oOP;
    logic [31:0] oAluA;
    logic [31:0] oAluB;
    logic [31:0] iAluC;
    logic        iAluNEG;
    logic        iAluZERO;
    logic        oDone;
    logic [31:0] oResult;
    logic        oFlagN;
    logic        oFlagZ;

    modport slave (
        input  iValid, iCmd, iA, iB,
        input  iAluC, iAluNEG, iAluZERO,
        output oReady, oOP, oAluA, oAluB,
        output oDone, oResult, oFlagN, oFlagZ
    );

    modport master (
        output iValid, iCmd, iA, iB,
        output iAluC, iAluNEG, iAluZERO,
        input  oReady, oOP, oAluA, oAluB,
        input  oDone, oResult, oFlagN, oFlagZ
    );
endinterface

// File: rtl/alu_sequencer.sv
// Command front-end for the 32-bit ALU: ADD/SUB/CMP in one step,
// MUL as 32 shift-and-add steps through the same ALU adder.
module alu_sequencer (
    input  logic              iClk,
    input  logic              iRstN,
    alu_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2
    } state_e;

    localparam logic [1:0] CMD_ADD = 2'b00;
    localparam logic [1:0] CMD_SUB = 2'b01;
    localparam logic [1:0] CMD_CMP = 2'b10;
    localparam logic [1:0] CMD_MUL = 2'b11;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;

    state_e      state_q, state_d;
    logic [1:0]  cmd_q, cmd_d;
    // In MUL these hold the shifting multiplicand and multiplier.
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;
    logic        flag_n_q, flag_n_d;
    logic        flag_z_q, flag_z_d;

    logic        accept;

    assign accept = bus.iValid && (state_q == IDLE);

    assign bus.oReady  = (state_q == IDLE);
    assign bus.oDone   = done_q;
    assign bus.oResult = result_q;
    assign bus.oFlagN  = flag_n_q;
    assign bus.oFlagZ  = flag_z_q;

    always_comb begin
        bus.oOP   = OP_ADD;
        bus.oAluA = '0;
        bus.oAluB = '0;
        unique case (state_q)
            EXEC: begin
                bus.oOP   = (cmd_q == CMD_ADD) ? OP_ADD : OP_SUB;
                bus.oAluA = opa_q;
                bus.oAluB = opb_q;
            end
            MUL: begin
                bus.oOP   = OP_ADD;
                bus.oAluA = acc_q;
                bus.oAluB = opb_q[0] ? opa_q : '0;
            end
            default: begin
                bus.oOP   = OP_ADD;
                bus.oAluA = '0;
                bus.oAluB = '0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
        flag_n_d = flag_n_q;
        flag_z_d = flag_z_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cmd_d = bus.iCmd;
                    opa_d = bus.iA;
                    opb_d = bus.iB;
                    if (bus.iCmd == CMD_MUL) begin
                        state_d = MUL;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cmd_q != CMD_CMP) begin
                    result_d = bus.iAluC;
                end
                flag_n_d = bus.iAluNEG;
                flag_z_d = bus.iAluZERO;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            MUL: begin
                acc_d = bus.iAluC;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q + 5'd1;
                // No early exit: every MUL takes all 32 steps.
                if (cnt_q == 5'd31) begin
                    result_d = bus.iAluC;
                    flag_n_d = bus.iAluNEG;
                    flag_z_d = bus.iAluZERO;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q  <= IDLE;
            cmd_q    <= CMD_ADD;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU and
// a scoreboard queue of expected completions.
module tb_alu_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .iClk  (clk),
        .iRstN (rst_n),
        .bus   (bus)
    );

    assign bus.iAluC = (bus.oOP == 4'b0001) ? bus.oAluA - bus.oAluB
                                            : bus.oAluA + bus.oAluB;
    assign bus.iAluNEG  = bus.iAluC[31];
    assign bus.iAluZERO = (bus.iAluC == 32'd0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        n;
        logic        z;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] model_res = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] cmd, input logic [31:0] a,
                        input logic [31:0] b);
        exp_t        e;
        logic [31:0] c;
        case (cmd)
            2'b00:   c = a + b;
            2'b11:   c = a * b;
            default: c = a - b;
        endcase
        if (cmd != 2'b10) model_res = c;
        e.res = model_res;
        e.n   = c[31];
        e.z   = (c == 32'd0);
        e.lat = (cmd == 2'b11) ? 32 : 1;
        e.acc = cyc;
        sb.push_back(e);
    endtask

    // Called just after a negedge; returns at the negedge after accept.
    task automatic send(input string tag, input logic [1:0] cmd,
                        input logic [31:0] a, input logic [31:0] b);
        int w = 0;
        bus.iValid = 1'b1;
        bus.iCmd   = cmd;
        bus.iA     = a;
        bus.iB     = b;
        while (!bus.oReady && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " ready"}, {31'd0, bus.oReady}, 32'd1);
        @(negedge clk);
        bus.iValid = 1'b0;
        push(cmd, a, b);
    endtask

    // Returns at the negedge where oDone is seen.
    task automatic wait_done(input string tag);
        int   w = 0;
        exp_t e;
        while (!bus.oDone && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " done seen"}, {31'd0, bus.oDone}, 32'd1);
        chk({tag, " sb pending"}, sb.size(), 32'd1);
        if (bus.oDone && sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, " result"}, bus.oResult, e.res);
            chk({tag, " flagN"}, {31'd0, bus.oFlagN}, {31'd0, e.n});
            chk({tag, " flagZ"}, {31'd0, bus.oFlagZ}, {31'd0, e.z});
            chk({tag, " latency"}, cyc - e.acc, e.lat);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " ready"}, {31'd0, bus.oReady}, 32'd1);
        chk({tag, " done"}, {31'd0, bus.oDone}, 32'd0);
        chk({tag, " result"}, bus.oResult, 32'd0);
        chk({tag, " N"}, {31'd0, bus.oFlagN}, 32'd0);
        chk({tag, " Z"}, {31'd0, bus.oFlagZ}, 32'd0);
        chk({tag, " op"}, {28'd0, bus.oOP}, 32'd0);
        chk({tag, " aluA"}, bus.oAluA, 32'd0);
        chk({tag, " aluB"}, bus.oAluB, 32'd0);
    endtask

    initial begin
        int quiet;

        bus.iValid = 1'b1;
        bus.iCmd   = 2'b00;
        bus.iA     = 32'd1;
        bus.iB     = 32'd1;

        // Reset held with a request pending: nothing may be accepted.
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n      = 1'b1;
        bus.iValid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post-rst done", {31'd0, bus.oDone}, 32'd0);
        end

        send("add5+7", 2'b00, 32'd5, 32'd7);
        chk("add5+7 op", {28'd0, bus.oOP}, 32'd0);
        chk("add5+7 aluA", bus.oAluA, 32'd5);
        chk("add5+7 aluB", bus.oAluB, 32'd7);
        wait_done("add5+7");
        @(negedge clk);
        chk("done one cycle", {31'd0, bus.oDone}, 32'd0);

        send("add wrap", 2'b00, 32'hFFFF_FFFF, 32'd1);
        wait_done("add wrap");

        send("sub3-5", 2'b01, 32'd3, 32'd5);
        chk("sub op", {28'd0, bus.oOP}, 32'd1);
        wait_done("sub3-5");

        send("cmp9,9", 2'b10, 32'd9, 32'd9);
        chk("cmp op", {28'd0, bus.oOP}, 32'd1);
        wait_done("cmp9,9");

        send("mul6x7", 2'b11, 32'd6, 32'd7);
        wait_done("mul6x7");

        send("mul7xneg1", 2'b11, 32'd7, 32'hFFFF_FFFF);
        wait_done("mul7xneg1");

        // Hold an ADD request while the MUL runs; it lands on the
        // edge that ends the MUL's done cycle.
        send("mul wrap", 2'b11, 32'h0001_0000, 32'h0001_0000);
        bus.iValid = 1'b1;
        bus.iCmd   = 2'b00;
        bus.iA     = 32'd20;
        bus.iB     = 32'd22;
        repeat (5) begin
            @(negedge clk);
            chk("busy ready", {31'd0, bus.oReady}, 32'd0);
            chk("busy done", {31'd0, bus.oDone}, 32'd0);
        end
        wait_done("mul wrap");
        @(negedge clk);
        bus.iValid = 1'b0;
        push(2'b00, 32'd20, 32'd22);
        chk("held add aluA", bus.oAluA, 32'd20);
        chk("held add aluB", bus.oAluB, 32'd22);
        wait_done("held add");

        // Abort a MUL at step 10 with an asynchronous reset.
        send("mul abort", 2'b11, 32'd123, 32'd456);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("mid-rst");
        sb.delete();
        model_res = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.oDone) quiet++;
        end
        chk("no done after abort", quiet, 32'd0);
        chk("abort result", bus.oResult, 32'd0);

        send("add1+1", 2'b00, 32'd1, 32'd1);
        wait_done("add1+1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
